spi_config_sequencer: RTL and testbench

Sequences SPI write frames into the on-chip SPI peripheral that owns the output-enable, PWM-enable and PWM duty-cycle registers. Write requests (7-bit address, 8-bit data) arrive over a valid/ready handshake and are buffered in a small FIFO. Each request is serialised as one 16-bit mode-0 frame on ncs/sclk/copi, which the peripheral samples through its 2-FF synchronisers. The block lets on-chip logic configure the peripheral without an external SPI master.

---
 rtl/spi_cfg_pkg.sv | 33 +++
 rtl/spi_cfg_fifo.sv | 47 ++++
 rtl/spi_config_sequencer.sv | 155 +++++++++++++++
 tb/tb_spi_config_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration sequencer.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } seq_state_e;

  localparam int   FRAME_BITS    = 16;
  localparam logic SPI_WRITE_BIT = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'd0;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'd1;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'd2;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'd3;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'd4;
  localparam logic [6:0] MAX_VALID_ADDR   = 7'd4;

  // One buffered write request; 15 bits, the FIFO entry width.
  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } spi_req_t;

  // Full on-wire frame: write flag, address, data, sent MSB first.
  function automatic logic [FRAME_BITS-1:0] frame_word(spi_req_t r);
    return {SPI_WRITE_BIT, r.addr, r.data};
  endfunction

endpackage

// File: rtl/spi_cfg_fifo.sv
// Request FIFO: synchronous, power-of-two depth, async active-low reset.
// Reset only clears pointers/count, so buffered contents are discarded.
module spi_cfg_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_q];

  // Pointer and occupancy tracking; push+pop together leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_config_sequencer.sv
// Serialises buffered register writes as 16-bit mode-0 SPI frames.
// Optional build macro SPI_SEQ_ADDR_CHECK_EN: requests with an address
// above MAX_VALID_ADDR are handshaken but dropped, and addr_err pulses.
module spi_config_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NCS_GAP    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       ncs,
  output logic       sclk,
  output logic       copi,
  output logic       busy,
  output logic       frame_done,
  output logic       addr_err
);
  localparam logic [7:0] DIV_RLD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RLD = 8'(NCS_GAP - 1);

  seq_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;     // half-period / gap counter
  logic [4:0]            bit_q, bit_d;     // falling edges seen this frame
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  phase_q, phase_d; // sclk level while in SHIFT
  logic                  done_q, done_d;

  logic        accept, push, pop, fifo_full, fifo_empty;
  logic [14:0] fifo_rdata;
  logic        tick;

  assign accept    = req_valid && req_ready;
  assign req_ready = !fifo_full;
  assign pop       = (state_q == IDLE) && !fifo_empty;
  assign tick      = (cnt_q == 8'd0);

`ifdef SPI_SEQ_ADDR_CHECK_EN
  logic addr_ok, addr_err_q;
  assign addr_ok  = (req_addr <= MAX_VALID_ADDR);
  assign push     = accept && addr_ok;
  assign addr_err = addr_err_q;

  // Flag a rejected request the cycle after it is handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else        addr_err_q <= accept && !addr_ok;
  end
`else
  assign push     = accept;
  assign addr_err = 1'b0;
`endif

  spi_cfg_fifo #(.WIDTH(15), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .push_i  (push),
    .wdata_i ({req_addr, req_data}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // FSM and datapath state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      phase_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      phase_q <= phase_d;
      done_q  <= done_d;
    end
  end

  // Next-state: each phase lasts until the down-counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? cnt_q : cnt_q - 8'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = DIV_RLD;
        if (!fifo_empty) begin
          state_d = SETUP;
          shift_d = frame_word(spi_req_t'(fifo_rdata));
          bit_d   = '0;
          phase_d = 1'b1;
        end
      end
      SETUP: if (tick) begin
        state_d = SHIFT;
        cnt_d   = DIV_RLD;
        phase_d = 1'b1;
      end
      SHIFT: if (tick) begin
        cnt_d = DIV_RLD;
        if (phase_q) begin
          // falling sclk: advance next bit onto copi
          phase_d = 1'b0;
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_d   = bit_q + 5'd1;
        end else if (bit_q == 5'(FRAME_BITS)) begin
          state_d = HOLD;
        end else begin
          phase_d = 1'b1;
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        cnt_d   = GAP_RLD;
        done_d  = 1'b1;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs decoded from registered state.
  always_comb begin
    ncs  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    busy = pop;
    unique case (state_q)
      SETUP, SHIFT, HOLD: begin
        ncs  = 1'b0;
        copi = shift_q[FRAME_BITS-1];
        sclk = (state_q == SHIFT) && phase_q;
        busy = 1'b1;
      end
      GAP:     busy = 1'b1;
      default: ;
    endcase
  end

  assign frame_done = done_q;

endmodule

// File: tb/tb_spi_config_sequencer.sv
// Self-checking bench for spi_config_sequencer: directed steps plus random
// requests, scored against a queue of expected frame words.
module tb_spi_config_sequencer;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int NCS_GAP    = 8;
  localparam int FRAME_LEN  = 34 * CLK_DIV;
  localparam int PERIOD     = FRAME_LEN + NCS_GAP + 1;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req_valid = 1'b0, req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       ncs, sclk, copi, busy, frame_done, addr_err;

  spi_config_sequencer #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .NCS_GAP(NCS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .ncs(ncs), .sclk(sclk),
    .copi(copi), .busy(busy), .frame_done(frame_done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference model: expected frames in order, plus a peripheral register file.
  logic [15:0] exp_q[$];
  logic [7:0]  regs [0:127];

  function automatic bit addr_ok(input logic [6:0] a);
`ifdef SPI_SEQ_ADDR_CHECK_EN
    return a <= 7'd4;
`else
    return 1'b1;
`endif
  endfunction

  // Wire monitor: decodes each frame from the pins.
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, b2b = 1'b0;
  int          len = 0, nbits = 0, prev_fall = 0, frames = 0, fd_pulses = 0;
  logic [15:0] word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0; prev_ncs = 1'b1; prev_sclk = 1'b0; b2b = 1'b0; nbits = 0;
    end else begin
      if (frame_done) fd_pulses++;
      if (prev_ncs && !ncs) begin
        in_frame = 1'b1; len = 0; nbits = 0; word = '0;
        if (b2b) chk("b2b_period", cyc - prev_fall, PERIOD);
        prev_fall = cyc;
      end
      if (in_frame && !ncs) len++;
      if (in_frame && !prev_sclk && sclk) begin
        word = {word[14:0], copi};
        nbits++;
      end
      if (in_frame && !prev_ncs && ncs) begin
        in_frame = 1'b0;
        chk("ncs_low_len", len, FRAME_LEN);
        chk("sclk_rises", nbits, 16);
        chk("frame_done_at_ncs_rise", frame_done, 1);
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("frame_word", word, exp_q.pop_front());
        regs[word[14:8]] = word[7:0];
        frames++;
        b2b = exp_q.size() > 0;
      end
      prev_ncs = ncs; prev_sclk = sclk;
    end
  end

  // Present one request at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [6:0] a, input logic [7:0] d, output int acc_cyc);
    int n = 0;
    bit acc = 1'b0;
    req_addr = a; req_data = d; req_valid = 1'b1;
    while (!acc && n < 2000) begin
      acc = req_ready;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    chk("accept_in_time", acc, 1);
    if (acc && addr_ok(a)) exp_q.push_back({1'b1, a, d});
    chk("addr_err_after_accept", addr_err, addr_ok(a) ? 0 : 1);
    acc_cyc = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || ncs == 1'b0 || exp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_in_time", n < bound, 1);
  endtask

  initial begin
    int t, t5, lat, lows, pf;
    for (int i = 0; i < 128; i++) regs[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ncs", ncs, 1);        chk("rst_sclk", sclk, 0);
    chk("rst_copi", copi, 0);      chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write and accept-to-ncs latency
    send(7'h00, 8'hA5, t);
    lat = 0;
    while (ncs && lat < 50) begin @(negedge clk); lat++; end
    chk("accept_to_ncs_low", lat, 1);
    wait_idle(1000);
    chk("reg0", regs[0], 8'hA5);
    chk("frames_single", frames, 1);
    chk("frame_done_pulses_single", fd_pulses, 1);

    // Peripheral register writes
    send(7'h04, 8'h80, t); wait_idle(1000);
    chk("pwm_duty", regs[4], 8'h80);
    send(7'h02, 8'hFF, t); wait_idle(1000);
    chk("en_pwm_7_0", regs[2], 8'hFF);

    // Back-to-back burst that fills the FIFO
    for (int i = 0; i <= FIFO_DEPTH; i++) send(7'(i), 8'(8'h10 + i), t5);
    chk("ready_low_when_full", req_ready, 0);
    send(7'h01, 8'h99, t);
    chk("full_reopen_delay", t - t5, PERIOD + 2 - FIFO_DEPTH);
    wait_idle(4000);
    chk("frames_after_burst", frames, 9);

    // Push during GAP with an empty FIFO
    send(7'h01, 8'h3C, t);
    lat = 0;
    while (!(ncs == 1'b0) && lat < 50) begin @(negedge clk); lat++; end
    while (ncs == 1'b0 && lat < 400) begin @(negedge clk); lat++; end
    repeat (2) @(negedge clk);
    pf = prev_fall;
    send(7'h03, 8'hC3, t);
    lows = 0; lat = 0;
    while (ncs && lat < 100) begin
      if (!busy) lows++;
      @(negedge clk); lat++;
    end
    chk("busy_continuous_gap", lows, 0);
    chk("gap_push_start", cyc - pf, PERIOD);
    wait_idle(1000);

    // Reset mid-frame discards the frame and the FIFO
    send(7'h11, 8'h22, t);
    send(7'h12, 8'h34, t);
    lat = 0;
    while (nbits < 7 && lat < 400) begin @(negedge clk); lat++; end
    chk("reached_bit7", nbits >= 7, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ncs", ncs, 1);     chk("midrst_sclk", sclk, 0);
    chk("midrst_copi", copi, 0);   chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (200) begin @(negedge clk); if (!ncs) lows++; end
    chk("no_frame_after_reset", lows, 0);
    send(7'h03, 8'h5A, t); wait_idle(1000);
    chk("reg3_after_reset", regs[3], 8'h5A);

    // Out-of-range address
    send(7'h05, 8'h66, t);
    @(negedge clk);
    chk("addr_err_one_cycle", addr_err, 0);
    lows = 0;
    repeat (FRAME_LEN + NCS_GAP + 20) begin @(negedge clk); if (!ncs) lows++; end
    chk("addr5_ncs_low_cycles", lows, addr_ok(7'h05) ? FRAME_LEN - 1 : 0);
    wait_idle(1000);

    // Random requests with random spacing
    for (int i = 0; i < 16; i++) begin
`ifdef SPI_SEQ_ADDR_CHECK_EN
      send(7'($urandom_range(0, 7)), 8'($urandom), t);
`else
      send(7'($urandom_range(0, 127)), 8'($urandom), t);
`endif
      repeat ($urandom_range(0, 160)) @(negedge clk);
    end
    wait_idle(20000);

    chk("queue_drained", exp_q.size(), 0);
    chk("frame_done_pulses_total", fd_pulses, frames);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
